alu_opnd_stage: RTL
===================

Name: alu_opnd_stage

Overview:
- Parametrised successor to the ALU source-operand select: a registered ID/EX operand stage.
- Per-operand forwarding select, immediate extension (zero/sign/upper), register-vs-immediate select for operand B.
- Valid/ready pipeline register with stall hold and flush.
- Feeds the ALU and the store-data path one cycle after acceptance.

Parameters:
- DATA_W, 32, datapath width.
- IMM_W, 16, raw immediate width; must be <= DATA_W.
- NUM_FWD, 2, number of forwarding sources (e.g. EX/MEM, MEM/WB).
- FSEL_W, $clog2(NUM_FWD+1), forward-select width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream has an operand set
- in_ready  out  1  stage can accept
- rs_data  in  DATA_W  register-file value for operand A
- rt_data  in  DATA_W  register-file value for operand B / store data
- imm  in  IMM_W  raw immediate
- ext_mode  in  2  00 zero-ext, 01 sign-ext, 10 upper (imm << (DATA_W-IMM_W)), 11 reserved
- alusrc  in  1  1 = operand B from register, 0 = extended immediate
- fwd_sel_a  in  FSEL_W  0 = rs_data, k = fwd_data[k-1]
- fwd_sel_b  in  FSEL_W  0 = rt_data, k = fwd_data[k-1]
- fwd_data  in  NUM_FWD*DATA_W  packed forwarding values; source k-1 at bits [k*DATA_W-1 -: DATA_W]
- flush  in  1  kill stage contents
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU stage consumes
- op_a  out  DATA_W  registered operand A
- op_b  out  DATA_W  registered operand B
- store_data  out  DATA_W  registered forwarded rt value (for SW), independent of alusrc

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. On rst_n=0 at the clk edge: out_valid=0, op_a=op_b=store_data=0.
- Acceptance:
  - in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
  - Accept = in_valid && in_ready.
  - Latency is 1 cycle: accepted operands appear on outputs at the next edge.
  - Full throughput when out_ready held at 1.
- Forwarding:
  - A_reg = fwd_sel_a==0 ? rs_data : fwd_data[fwd_sel_a-1].
  - B_reg is the same, using fwd_sel_b and rt_data.
  - Select value > NUM_FWD falls back to the register-file value.
- Immediate extension:
  - Zero: upper bits 0.
  - Sign: replicate imm[IMM_W-1].
  - Upper: imm in MSBs, low bits 0.
  - Mode 11 behaves as zero-ext.
- Operand B: alusrc=1 selects B_reg, alusrc=0 selects the extended immediate. store_data always captures B_reg.
- Register update:
  - On accept, op_a/op_b/store_data load and out_valid=1.
  - Else if out_ready && out_valid, out_valid=0 and data holds.
  - Else (stall: out_valid=1, out_ready=0) everything holds, regardless of input changes.
- Flush: flush=1 forces out_valid=0 at the next edge, overriding accept. Data registers are not loaded. in_ready is unaffected in that cycle.
- Priority: rst_n > flush > accept > drain.
- Reset mid-stall drops held data (out_valid=0).

Optional Feature:
- Macro ALU_OPND_FWD_EN.
- Defined: forwarding muxes as above.
- Undefined: fwd_sel_a/fwd_sel_b/fwd_data are ignored (ports remain for pin compatibility); A_reg=rs_data, B_reg=rt_data; no forwarding logic synthesised.

Decomposition:
- Package alu_opnd_pkg:
  - ext_mode constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10.
  - Default DATA_W/IMM_W localparams.
  - fsel_width(NUM_FWD) function.
- Sub-module opnd_fwd_mux: combinational (DATA_W, NUM_FWD) select with range fallback, instantiated twice.
- Immediate extender and pipeline register inline.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, op_a=op_b=store_data=0; in_ready=1 after release.
- Extension: imm=16'h8001, alusrc=0 -> op_b=32'h00008001 (mode 00), 32'hFFFF8001 (01), 32'h80010000 (10), 32'h00008001 (11), each one cycle after accept.
- Forwarding (ALU_OPND_FWD_EN): rs_data=1, fwd_data={32'hBBBB,32'hAAAA}, fwd_sel_a=1 -> op_a=32'hAAAA; fwd_sel_a=2 -> 32'hBBBB; fwd_sel_a=3 -> 32'h1. Without the macro, all three give 32'h1.
- Store path: alusrc=0, imm=4, fwd_sel_b=2 with fwd_data[1]=32'hDEAD -> op_b=32'h4, store_data=32'hDEAD.
- Stall: load op_a=5, then out_ready=0 for 3 cycles while inputs change -> in_ready=0, op_a stays 5, out_valid=1; raising out_ready with in_valid=1 and new rs=6 -> next cycle op_a=6.
- Flush: flush=1 with in_valid=1, in_ready=1 -> out_valid=0 next cycle, op_a unchanged; back-to-back stream with out_ready=1 gives one output per cycle.

Source files
------------

// File: rtl/alu_opnd_pkg.sv
// Shared constants and helpers for the ID/EX operand stage: extension modes,
// default widths and the forward-select width function.
package alu_opnd_pkg;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 16;

  // Select encodes 0 = register file, 1..num_fwd = forwarding source; never narrower than 1 bit.
  function automatic int fsel_width(input int num_fwd);
    int w;
    w = $clog2(num_fwd + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/opnd_fwd_mux.sv
// Combinational forwarding select: 0 picks the register-file value,
// k picks fwd_data source k-1; out-of-range selects fall back to the register value.
module opnd_fwd_mux
  import alu_opnd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_FWD = 2,
  localparam int FSEL_W = fsel_width(NUM_FWD)
) (
  input  logic [FSEL_W-1:0]         sel,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data
);

  always_comb begin
    data = reg_data;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (sel == FSEL_W'(k)) data = fwd_data[k*DATA_W-1 -: DATA_W];
    end
  end

endmodule

// File: rtl/alu_opnd_stage.sv
// Registered ID/EX operand stage: forwarding, immediate extension, B-source select,
// valid/ready register with stall hold and flush. Forwarding muxes only with ALU_OPND_FWD_EN.
module alu_opnd_stage
  import alu_opnd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMM_W   = DEF_IMM_W,
  parameter int NUM_FWD = 2,
  localparam int FSEL_W = fsel_width(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         rs_data,
  input  logic [DATA_W-1:0]         rt_data,
  input  logic [IMM_W-1:0]          imm,
  input  logic [1:0]                ext_mode,
  input  logic                      alusrc,
  input  logic [FSEL_W-1:0]         fwd_sel_a,
  input  logic [FSEL_W-1:0]         fwd_sel_b,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         op_a,
  output logic [DATA_W-1:0]         op_b,
  output logic [DATA_W-1:0]         store_data
);

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] raw,
                                                input logic [1:0]       mode);
    logic signed [IMM_W-1:0] s;
    s = $signed(raw);
    case (mode)
      EXT_SIGN:  ext_imm = DATA_W'(s);
      EXT_UPPER: ext_imm = DATA_W'(raw) << (DATA_W - IMM_W);
      default:   ext_imm = DATA_W'(raw);
    endcase
  endfunction

  logic [DATA_W-1:0] a_reg_p0, b_reg_p0, imm_ext_p0, op_b_p0;
  logic [DATA_W-1:0] op_a_p1, op_b_p1, store_p1;
  logic              vld_p1;
  logic              accept_p0;

  // p0: operand selection from decode-stage inputs
`ifdef ALU_OPND_FWD_EN
  opnd_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
    .sel      (fwd_sel_a),
    .reg_data (rs_data),
    .fwd_data (fwd_data),
    .data     (a_reg_p0)
  );

  opnd_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
    .sel      (fwd_sel_b),
    .reg_data (rt_data),
    .fwd_data (fwd_data),
    .data     (b_reg_p0)
  );
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_sel_a, fwd_sel_b, fwd_data};
  assign a_reg_p0   = rs_data;
  assign b_reg_p0   = rt_data;
`endif

  assign imm_ext_p0 = ext_imm(imm, ext_mode);
  assign op_b_p0    = alusrc ? b_reg_p0 : imm_ext_p0;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  // p1: operand register feeding the ALU and store-data path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      op_a_p1  <= '0;
      op_b_p1  <= '0;
      store_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      op_a_p1  <= a_reg_p0;
      op_b_p1  <= op_b_p0;
      store_p1 <= b_reg_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign op_a       = op_a_p1;
  assign op_b       = op_b_p1;
  assign store_data = store_p1;

endmodule
